dual_sample_fifo: RTL and testbench
===================================

// Module: dual_sample_fifo
// PURPOSE
//   Downstream capture stage for the dual-phase sine generator: takes the two
//   ROM sample streams (dout1/dout2 pair) and optionally decimates them.
//   Buffers sample pairs in a small synchronous FIFO and presents them to the
//   display/plot consumer over a valid/ready handshake.
//   Decouples the generator, which cannot stall, from a slow consumer.
//   Drops are flagged, never silent.
// PARAMETERS
//   D_WIDTH   8   width of each sample channel
//   DEPTH     16  FIFO entries (sample pairs); power of 2, >= 2
//   DEC_WIDTH 4   width of the decimation control input
// PORTS
//   clk        in   1                 system clock, rising edge
//   rst        in   1                 async reset, ACTIVE-LOW (asserts immediately, deasserts sync to clk)
//   in_valid   in   1                 sample pair present this cycle (driven by generator en)
//   din1       in   D_WIDTH           channel 1 sample
//   din2       in   D_WIDTH           channel 2 sample (phase-offset copy)
//   decim      in   DEC_WIDTH         samples discarded after each kept sample; 0 = keep all
//   out_ready  in   1                 consumer accepts head pair this cycle
//   out_valid  out  1                 head pair valid (= !empty)
//   dout1      out  D_WIDTH           head channel 1 sample
//   dout2      out  D_WIDTH           head channel 2 sample
//   count      out  $clog2(DEPTH)+1   entries held, 0..DEPTH
//   full       out  1                 count == DEPTH
//   empty      out  1                 count == 0
//   overflow   out  1                 sticky; set when a kept sample is dropped
// BEHAVIOUR
//   Reset (rst=0): count=0, empty=1, full=0, out_valid=0, overflow=0,
//     dout1/dout2=0, rd/wr pointers=0, decimation counter=0.
//   Decimation: dec_cnt counts down on each in_valid.
//     keep = in_valid && dec_cnt==0; on keep, dec_cnt <= decim.
//     On in_valid && dec_cnt!=0: sample discarded, dec_cnt <= dec_cnt-1.
//     A decim change takes effect at the next reload only.
//     in_valid=0 leaves dec_cnt unchanged.
//   push = keep && (!full || pop); pop = out_valid && out_ready.
//   Push while full with no pop: pair dropped, overflow <= 1.
//     overflow is cleared only by reset.
//   Push+pop when full: both occur; count stays DEPTH.
//   Push+pop when empty: pop is impossible (out_valid=0).
//     Push only; no fall-through.
//   Latency: a pair kept at edge k is on dout1/dout2 with out_valid=1 in cycle
//     k+1 (first-word show-ahead).
//   dout1/dout2 always reflect the head entry and hold their value while
//     out_valid=1 && !out_ready.
//   When empty, dout1/dout2 hold their last value; the consumer ignores them.
//   Pointers: $clog2(DEPTH) bits, wrap modulo DEPTH.
//   count: +1 on push only, -1 on pop only, unchanged on both or neither.
//   FIFO order is strict; din1/din2 of one pair are never split.
//   Reset mid-operation: all contents discarded; outputs return to reset values
//     asynchronously.
// CONFIGURATION
//   SAMPLE_FIFO_DROP_CNT_EN defined: adds output drop_cnt [7:0].
//     drop_cnt is reset to 0.
//     It increments on every dropped pair (full, no pop) and saturates at 255.
//     overflow = (drop_cnt != 0).
//   Undefined: the drop_cnt port and its counter are absent.
//     overflow behaves as the sticky bit above.
// TESTING
//   decim=0, in_valid=1 for 5 cycles with din1=10..14, out_ready=0:
//     -> count=5; then out_ready=1 gives dout1=10..14 in order, then empty=1.
//   decim=2, in_valid=1 continuous, din1=0,1,2,...:
//     -> FIFO receives 0,3,6,9...
//     Change decim to 0 mid-run -> new rate after the current countdown ends.
//   out_ready=0, 18 kept pairs, DEPTH=16:
//     -> full=1, count=16, overflow=1, contents 0..15.
//     With SAMPLE_FIFO_DROP_CNT_EN: drop_cnt=2.
//   full with out_ready=1 and a kept sample in the same cycle:
//     -> count stays 16, overflow stays 0, head advances by one.
//   Empty FIFO, single kept pair at edge k:
//     -> out_valid=0 in cycle k, 1 in cycle k+1.
//   Reset asserted mid-stream with count=7:
//     -> count=0, out_valid=0, overflow=0 immediately.
//     After release, first kept pair appears as head.

Source files
------------

// File: rtl/dual_sample_fifo.sv
// -----------------------------------------------------------------------------
// dual_sample_fifo
//   Capture stage for the dual-phase sine generator. It optionally decimates
//   the incoming sample-pair stream, buffers kept pairs in a small synchronous
//   FIFO and presents the head pair over a valid/ready handshake. The
//   generator cannot stall. A kept pair that arrives while the FIFO is full
//   (and no pop occurs) is dropped, and the drop is flagged on 'overflow'.
//
// Optional feature: define SAMPLE_FIFO_DROP_CNT_EN to add the drop_cnt output
//   (saturating 8-bit count of dropped pairs). In that build,
//   overflow = (drop_cnt != 0).
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active low
//   in_valid   in   sample pair present this cycle
//   din1/din2  in   channel 1 / channel 2 sample
//   decim      in   samples discarded after each kept sample (0 = keep all)
//   out_ready  in   consumer accepts the head pair this cycle
//   out_valid  out  head pair valid (FIFO not empty)
//   dout1/2    out  head pair; holds its last value while empty
//   count      out  entries held, 0..DEPTH
//   full       out  count == DEPTH
//   empty      out  count == 0
//   overflow   out  sticky drop flag, cleared only by reset
//   drop_cnt   out  (SAMPLE_FIFO_DROP_CNT_EN only) saturating drop count
// -----------------------------------------------------------------------------
module dual_sample_fifo #(
   parameter int D_WIDTH   = 8,
   parameter int DEPTH     = 16,
   parameter int DEC_WIDTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [D_WIDTH-1:0]         din1,
   input  logic [D_WIDTH-1:0]         din2,
   input  logic [DEC_WIDTH-1:0]       decim,
   input  logic                       out_ready,
   output logic                       out_valid,
   output logic [D_WIDTH-1:0]         dout1,
   output logic [D_WIDTH-1:0]         dout2,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow
`ifdef SAMPLE_FIFO_DROP_CNT_EN
   ,
   output logic [7:0]                 drop_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [D_WIDTH-1:0]   mem1_r [DEPTH];
   logic [D_WIDTH-1:0]   mem2_r [DEPTH];
   logic [AW-1:0]        wr_ptr_r;
   logic [AW-1:0]        rd_ptr_r;
   logic [DEC_WIDTH-1:0] dec_cnt_r;

   logic                 keep_s;
   logic                 pop_s;
   logic                 push_s;
   logic                 drop_s;
   logic [AW-1:0]        rd_next_s;
   logic [CW-1:0]        count_next_s;
   logic [D_WIDTH-1:0]   head1_s;
   logic [D_WIDTH-1:0]   head2_s;

   // Handshake decode, next count and next head pair.
   always_comb begin
      keep_s       = in_valid && (dec_cnt_r == {DEC_WIDTH{1'b0}});
      pop_s        = out_valid && out_ready;
      push_s       = keep_s && (!full || pop_s);
      drop_s       = keep_s && full && !pop_s;
      rd_next_s    = rd_ptr_r;
      count_next_s = count;
      head1_s      = dout1;
      head2_s      = dout2;
      if (pop_s) begin
         rd_next_s = rd_ptr_r + AW'(1);
      end else begin
         rd_next_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
         2'b10:   count_next_s = count + CW'(1);
         2'b01:   count_next_s = count - CW'(1);
         default: count_next_s = count;
      endcase
      // The new head is the pair being written only when it lands in the slot
      // the read pointer moves to (FIFO empty after any pop). When full with
      // push+pop the write slot is the old head, never rd_next_s.
      if (push_s && (wr_ptr_r == rd_next_s)) begin
         head1_s = din1;
         head2_s = din2;
      end else begin
         head1_s = mem1_r[rd_next_s];
         head2_s = mem2_r[rd_next_s];
      end
   end

   // Sample storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem1_r[wr_ptr_r] <= din1;
         mem2_r[wr_ptr_r] <= din2;
      end else begin
         mem1_r[wr_ptr_r] <= mem1_r[wr_ptr_r];
         mem2_r[wr_ptr_r] <= mem2_r[wr_ptr_r];
      end
   end

   // Pointers, occupancy flags, head registers and decimation counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r  <= {AW{1'b0}};
         rd_ptr_r  <= {AW{1'b0}};
         dec_cnt_r <= {DEC_WIDTH{1'b0}};
         count     <= {CW{1'b0}};
         full      <= 1'b0;
         empty     <= 1'b1;
         out_valid <= 1'b0;
         dout1     <= {D_WIDTH{1'b0}};
         dout2     <= {D_WIDTH{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         rd_ptr_r <= rd_next_s;
         // decim is sampled only at reload, so a change waits for the
         // current countdown to finish.
         if (in_valid) begin
            if (dec_cnt_r == {DEC_WIDTH{1'b0}}) begin
               dec_cnt_r <= decim;
            end else begin
               dec_cnt_r <= dec_cnt_r - DEC_WIDTH'(1);
            end
         end else begin
            dec_cnt_r <= dec_cnt_r;
         end
         count     <= count_next_s;
         full      <= (count_next_s == CW'(DEPTH));
         empty     <= (count_next_s == {CW{1'b0}});
         out_valid <= (count_next_s != {CW{1'b0}});
         if (count_next_s != {CW{1'b0}}) begin
            dout1 <= head1_s;
            dout2 <= head2_s;
         end else begin
            dout1 <= dout1;
            dout2 <= dout2;
         end
      end
   end

`ifdef SAMPLE_FIFO_DROP_CNT_EN
   // Saturating count of dropped pairs; overflow is derived from it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drop_cnt <= 8'd0;
      end else if (drop_s && (drop_cnt != 8'hFF)) begin
         drop_cnt <= drop_cnt + 8'd1;
      end else begin
         drop_cnt <= drop_cnt;
      end
   end

   assign overflow = (drop_cnt != 8'd0);
`else
   // Sticky drop flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow <= 1'b0;
      end else if (drop_s) begin
         overflow <= 1'b1;
      end else begin
         overflow <= overflow;
      end
   end
`endif

endmodule

// File: tb/tb_dual_sample_fifo.sv
module tb_dual_sample_fifo;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] din1;
   logic [7:0] din2;
   logic [3:0] decim;
   logic       out_ready;
   logic       out_valid;
   logic [7:0] dout1;
   logic [7:0] dout2;
   logic [4:0] count;
   logic       full;
   logic       empty;
   logic       overflow;
`ifdef SAMPLE_FIFO_DROP_CNT_EN
   logic [7:0] drop_cnt;
`endif

   int n_pass  = 0;
   int n_total = 0;

   dual_sample_fifo #(.D_WIDTH(8), .DEPTH(DEPTH), .DEC_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .din1(din1), .din2(din2),
      .decim(decim), .out_ready(out_ready), .out_valid(out_valid),
      .dout1(dout1), .dout2(dout2), .count(count), .full(full),
      .empty(empty), .overflow(overflow)
`ifdef SAMPLE_FIFO_DROP_CNT_EN
      , .drop_cnt(drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Advance one clock; returns 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one sample pair; din2 is a fixed function of din1 so pairing is visible.
   task automatic drive(input logic v, input logic [7:0] d, input logic r);
      in_valid  = v;
      din1      = d;
      din2      = d ^ 8'hA5;
      out_ready = r;
   endtask

   task automatic do_reset();
      drive(1'b0, 8'd0, 1'b0);
      decim = 4'd0;
      rst   = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   typedef struct {
      logic       iv;
      logic [7:0] d1;
      logic       rdy;
      logic       e_ov;
      logic [7:0] e_d1;
      logic [4:0] e_cnt;
      logic       e_emp;
   } vec_t;

   vec_t tbl[10];

   // Behavioural reference: a queue of pairs plus the decimation counter.
   logic [15:0] mq[$];
   int          m_dec;
   int          m_drops;
   logic [15:0] m_head;

   initial begin
      tbl[0] = '{1'b1, 8'd10, 1'b0, 1'b1, 8'd10, 5'd1, 1'b0};
      tbl[1] = '{1'b1, 8'd11, 1'b0, 1'b1, 8'd10, 5'd2, 1'b0};
      tbl[2] = '{1'b1, 8'd12, 1'b0, 1'b1, 8'd10, 5'd3, 1'b0};
      tbl[3] = '{1'b1, 8'd13, 1'b0, 1'b1, 8'd10, 5'd4, 1'b0};
      tbl[4] = '{1'b1, 8'd14, 1'b0, 1'b1, 8'd10, 5'd5, 1'b0};
      tbl[5] = '{1'b0, 8'd0,  1'b1, 1'b1, 8'd11, 5'd4, 1'b0};
      tbl[6] = '{1'b0, 8'd0,  1'b1, 1'b1, 8'd12, 5'd3, 1'b0};
      tbl[7] = '{1'b0, 8'd0,  1'b1, 1'b1, 8'd13, 5'd2, 1'b0};
      tbl[8] = '{1'b0, 8'd0,  1'b1, 1'b1, 8'd14, 5'd1, 1'b0};
      tbl[9] = '{1'b0, 8'd0,  1'b1, 1'b0, 8'd14, 5'd0, 1'b1};

      rst = 1'b1;
      drive(1'b0, 8'd0, 1'b0);
      decim = 4'd0;
      #2;
      rst = 1'b0;
      #1;
      chk("reset_count", 32'(count), 32'd0);
      chk("reset_empty", 32'(empty), 32'd1);
      chk("reset_full", 32'(full), 32'd0);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_overflow", 32'(overflow), 32'd0);
      chk("reset_dout1", 32'(dout1), 32'd0);
      do_reset();

      // Table: five pushes with out_ready low, then drain in order.
      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].iv, tbl[i].d1, tbl[i].rdy);
         tick();
         chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
         chk($sformatf("tbl%0d_dout1", i), 32'(dout1), 32'(tbl[i].e_d1));
         chk($sformatf("tbl%0d_dout2", i), 32'(dout2), 32'(tbl[i].e_d1 ^ 8'hA5));
         chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
         chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].e_emp));
      end

      // Decimation by 3, then decim=0 after the countdown started at sample 9.
      do_reset();
      decim = 4'd2;
      for (int i = 0; i < 15; i++) begin
         if (i == 10) decim = 4'd0;
         drive(1'b1, 8'(i), 1'b0);
         tick();
      end
      drive(1'b0, 8'd0, 1'b0);
      chk("decim_count", 32'(count), 32'd7);
      begin
         logic [7:0] exp_seq [7];
         exp_seq = '{8'd0, 8'd3, 8'd6, 8'd9, 8'd12, 8'd13, 8'd14};
         for (int i = 0; i < 7; i++) begin
            chk($sformatf("decim_head%0d", i), 32'(dout1), 32'(exp_seq[i]));
            drive(1'b0, 8'd0, 1'b1);
            tick();
         end
      end
      chk("decim_empty", 32'(empty), 32'd1);

      // Overflow: 18 kept pairs into a 16-deep FIFO.
      do_reset();
      for (int i = 0; i < 18; i++) begin
         drive(1'b1, 8'(i), 1'b0);
         tick();
      end
      drive(1'b0, 8'd0, 1'b0);
      chk("ovf_full", 32'(full), 32'd1);
      chk("ovf_count", 32'(count), 32'd16);
      chk("ovf_overflow", 32'(overflow), 32'd1);
`ifdef SAMPLE_FIFO_DROP_CNT_EN
      chk("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
`endif
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("ovf_content%0d", i), 32'(dout1), 32'(i));
         drive(1'b0, 8'd0, 1'b1);
         tick();
      end
      chk("ovf_drained_empty", 32'(empty), 32'd1);
      chk("ovf_still_set", 32'(overflow), 32'd1);

      // Full with simultaneous push and pop.
      do_reset();
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 8'(i), 1'b0);
         tick();
      end
      chk("fullpp_pre_full", 32'(full), 32'd1);
      drive(1'b1, 8'd99, 1'b1);
      tick();
      drive(1'b0, 8'd0, 1'b0);
      chk("fullpp_count", 32'(count), 32'd16);
      chk("fullpp_overflow", 32'(overflow), 32'd0);
      chk("fullpp_head", 32'(dout1), 32'd1);

      // Single kept pair into an empty FIFO: visible one cycle later.
      do_reset();
      drive(1'b1, 8'd42, 1'b1);
      #1;
      chk("lat_cycle_k_valid", 32'(out_valid), 32'd0);
      tick();
      drive(1'b0, 8'd0, 1'b0);
      chk("lat_cycle_k1_valid", 32'(out_valid), 32'd1);
      chk("lat_cycle_k1_dout1", 32'(dout1), 32'd42);
      chk("lat_cycle_k1_dout2", 32'(dout2), 32'(8'd42 ^ 8'hA5));

      // Reset mid-stream with count=7 and overflow set.
      do_reset();
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, 8'(i), 1'b0);
         tick();
      end
      for (int i = 0; i < 9; i++) begin
         drive(1'b0, 8'd0, 1'b1);
         tick();
      end
      drive(1'b0, 8'd0, 1'b0);
      chk("mid_pre_count", 32'(count), 32'd7);
      chk("mid_pre_overflow", 32'(overflow), 32'd1);
      rst = 1'b0;
      #1;
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_overflow", 32'(overflow), 32'd0);
      chk("mid_rst_dout1", 32'(dout1), 32'd0);
      tick();
      rst = 1'b1;
      drive(1'b1, 8'd77, 1'b0);
      tick();
      drive(1'b0, 8'd0, 1'b0);
      chk("mid_after_head", 32'(dout1), 32'd77);
      chk("mid_after_count", 32'(count), 32'd1);

      // Randomized traffic against the queue model.
      do_reset();
      mq.delete();
      m_dec   = 0;
      m_drops = 0;
      m_head  = 16'd0;
      for (int c = 0; c < 1500; c++) begin
         int          rpct;
         logic        v;
         logic        r;
         logic [7:0]  d;
         logic        pop;
         logic        keep;
         rpct = ((c / 150) % 3 == 0) ? 10 : (((c / 150) % 3 == 1) ? 50 : 90);
         if ($urandom_range(0, 49) == 0) decim = 4'($urandom_range(0, 3));
         v = ($urandom_range(0, 99) < 70);
         r = ($urandom_range(0, 99) < rpct);
         d = 8'($urandom);
         drive(v, d, r);
         pop  = (mq.size() > 0) && r;
         keep = v && (m_dec == 0);
         if (v) m_dec = (m_dec == 0) ? int'(decim) : m_dec - 1;
         if (pop) void'(mq.pop_front());
         if (keep) begin
            if (mq.size() < DEPTH) mq.push_back({d, d ^ 8'hA5});
            else m_drops++;
         end
         if (mq.size() > 0) m_head = mq[0];
         tick();
         chk("rnd_count", 32'(count), 32'(mq.size()));
         chk("rnd_out_valid", 32'(out_valid), 32'(mq.size() > 0));
         chk("rnd_full", 32'(full), 32'(mq.size() == DEPTH));
         chk("rnd_empty", 32'(empty), 32'(mq.size() == 0));
         chk("rnd_head", 32'({dout1, dout2}), 32'(m_head));
         chk("rnd_overflow", 32'(overflow), 32'(m_drops > 0));
`ifdef SAMPLE_FIFO_DROP_CNT_EN
         chk("rnd_drop_cnt", 32'(drop_cnt), 32'((m_drops > 255) ? 255 : m_drops));
`endif
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
